shift_sequencer: RTL and testbench

Multi-cycle, bit-serial shift unit with a start/busy/done handshake, for the multicycle ARM datapath. It replaces the single-cycle combinational shifter when area matters more than latency. It takes the second ALU operand (Rm), the shift type, and either an immediate shamt5 or a register-specified amount (Rs), then steps one bit per cycle. It returns the shifted operand and the ARM shifter carry-out for the flags logic. The main FSM drives start and waits on done before using the result.

---
 rtl/shift_sequencer.sv | 139 +++++++++++++
 tb/tb_shift_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Bit-serial ARM operand shifter: captures Rm/type/amount on start, steps one bit
// per cycle, then presents the shifted operand and shifter carry with a done pulse.
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  sh_type,
  input  logic        sh_reg,
  input  logic [4:0]  shamt5,
  input  logic [31:0] rs_val,
  input  logic [31:0] rm_val,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  localparam int DATA_W = 32;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] r_p0;
  logic                     c_p0;
  logic [1:0]               ty_p0;
  logic                     rrx_p0;
  logic [5:0]               cnt_p0;

  logic [5:0]        n_acc;
  logic              rrx_acc;
  logic [DATA_W:0]   stepped;
  logic              accept;
  logic              unused_rs;

  // Only the low byte of Rs carries a shift amount.
  assign unused_rs = ^rs_val[31:8];

  // Number of single-bit steps needed to realise the requested ARM shift.
  function automatic logic [5:0] calc_steps(input logic       reg_mode,
                                            input logic [4:0] imm,
                                            input logic [7:0] amt,
                                            input logic [1:0] ty);
    logic [5:0] n;
    n = 6'd0;
    if (!reg_mode) begin
      case (ty)
        T_LSL:   n = {1'b0, imm};
        T_LSR,
        T_ASR:   n = (imm == 5'd0) ? 6'd32 : {1'b0, imm};
        default: n = (imm == 5'd0) ? 6'd1  : {1'b0, imm};
      endcase
    end else if (amt != 8'd0) begin
      case (ty)
        T_LSL,
        T_LSR:   n = (amt >= 8'd33) ? 6'd33 : amt[5:0];
        T_ASR:   n = (amt >= 8'd32) ? 6'd32 : amt[5:0];
        default: n = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
      endcase
    end
    return n;
  endfunction

  // One shift step; returns {carry, value}.
  function automatic logic [DATA_W:0] shift_step(input logic [DATA_W-1:0] r,
                                                 input logic              c,
                                                 input logic [1:0]        ty,
                                                 input logic              rrx);
    logic [DATA_W:0] o;
    case (ty)
      T_LSL:   o = {r[31], r[30:0], 1'b0};
      T_LSR:   o = {r[0], 1'b0, r[31:1]};
      T_ASR:   o = {r[0], r[31], r[31:1]};
      default: o = rrx ? {r[0], c, r[31:1]} : {r[0], r[0], r[31:1]};
    endcase
    return o;
  endfunction

  assign n_acc   = calc_steps(sh_reg, shamt5, rs_val[7:0], sh_type);
  assign rrx_acc = !sh_reg && (sh_type == T_ROR) && (shamt5 == 5'd0);
  assign stepped = shift_step(r_p0, c_p0, ty_p0, rrx_p0);
  assign accept  = (state == IDLE) && start;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (n_acc == 6'd0) ? DONE : SHIFT;
      SHIFT:   if (cnt_p0 <= 6'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: capture on acceptance, then one step per SHIFT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0    <= 6'd0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      r_p0   <= rm_val;
      c_p0   <= carry_in;
      ty_p0  <= sh_type;
      rrx_p0 <= rrx_acc;
      cnt_p0 <= n_acc;
      if (n_acc == 6'd0) begin
        result    <= rm_val;
        carry_out <= carry_in;
      end
    end else if (state == SHIFT) begin
      r_p0 <= stepped[DATA_W-1:0];
      c_p0 <= stepped[DATA_W];
      if (cnt_p0 != 6'd0) cnt_p0 <= cnt_p0 - 6'd1;
      if (cnt_p0 <= 6'd1) begin
        result    <= stepped[DATA_W-1:0];
        carry_out <= stepped[DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, carries and latencies.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  sh_type;
  logic        sh_reg;
  logic [4:0]  shamt5;
  logic [31:0] rs_val;
  logic [31:0] rm_val;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .sh_type(sh_type), .sh_reg(sh_reg),
    .shamt5(shamt5), .rs_val(rs_val), .rm_val(rm_val), .carry_in(carry_in),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic launch(input logic [1:0] ty, input logic rg, input logic [4:0] imm,
                        input logic [31:0] rs, input logic [31:0] rm, input logic cin);
    sh_type = ty; sh_reg = rg; shamt5 = imm; rs_val = rs; rm_val = rm; carry_in = cin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sh_type = ~ty; sh_reg = ~rg; shamt5 = ~imm; rs_val = ~rs; rm_val = ~rm; carry_in = ~cin;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] er, input logic ec, input int el);
    int lat;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_result"}, result, er);
    chk({tag, "_carry"}, carry_out, ec);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  task automatic run(input string tag, input logic [1:0] ty, input logic rg, input logic [4:0] imm,
                     input logic [31:0] rs, input logic [31:0] rm, input logic cin,
                     input logic [31:0] er, input logic ec, input int el);
    launch(ty, rg, imm, rs, rm, cin);
    finish_op(tag, er, ec, el);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sh_type = 2'b00; sh_reg = 1'b0; shamt5 = 5'd0;
    rs_val = '0; rm_val = '0; carry_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, carry_out, result}, 35'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("lsl_imm4",   2'b00, 1'b0, 5'd4,  32'h0,   32'h1000_000F, 1'b0, 32'h0000_00F0, 1'b1, 5);
    run("asr_imm0",   2'b10, 1'b0, 5'd0,  32'h0,   32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33);
    run("lsr_imm0",   2'b01, 1'b0, 5'd0,  32'h0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 33);
    run("rrx",        2'b11, 1'b0, 5'd0,  32'h0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 2);
    run("lsl_imm0",   2'b00, 1'b0, 5'd0,  32'h0,   32'h0000_ABCD, 1'b1, 32'h0000_ABCD, 1'b1, 1);
    run("ror_imm8",   2'b11, 1'b0, 5'd8,  32'h0,   32'h0000_00A5, 1'b0, 32'hA500_0000, 1'b1, 9);
    run("asr_imm1",   2'b10, 1'b0, 5'd1,  32'h0,   32'h8000_0001, 1'b0, 32'hC000_0000, 1'b1, 2);
    run("lsr_imm31",  2'b01, 1'b0, 5'd31, 32'h0,   32'h8000_0000, 1'b1, 32'h0000_0001, 1'b0, 32);
    run("lsr_reg33",  2'b01, 1'b1, 5'd0,  32'h121, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34);
    run("ror_reg64",  2'b11, 1'b1, 5'd0,  32'h40,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 33);
    run("lsl_reg32",  2'b00, 1'b1, 5'd0,  32'h20,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 33);
    run("lsl_reg40",  2'b00, 1'b1, 5'd0,  32'h28,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34);
    run("asr_reg200", 2'b10, 1'b1, 5'd0,  32'hC8,  32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33);
    run("asr_reg40",  2'b10, 1'b1, 5'd0,  32'h28,  32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 33);
    for (int t = 0; t < 4; t++)
      run("reg_zero", 2'(t), 1'b1, 5'd7, 32'h100, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1);

    // Start while busy must be ignored and not queued.
    launch(2'b01, 1'b0, 5'd8, 32'h0, 32'h0000_FF00, 1'b0);
    @(posedge clk); #1;
    sh_type = 2'b00; sh_reg = 1'b1; rs_val = 32'h3; rm_val = 32'hDEAD_BEEF; carry_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("busy_start", 32'h0000_00FF, 1'b0, 7);
    repeat (2) @(posedge clk);
    #1;
    chk("no_queue", {busy, result}, {1'b0, 32'h0000_00FF});

    // Start coincident with done is ignored.
    launch(2'b00, 1'b0, 5'd1, 32'h0, 32'h0000_0001, 1'b0);
    chk("coinc_done_seen", done, 0);
    @(posedge clk); #1;
    chk("coinc_done", done, 1);
    sh_type = 2'b00; sh_reg = 1'b0; shamt5 = 5'd3; rm_val = 32'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("coinc_ignored", {busy, done, result}, {2'b00, 32'h0000_0002});

    // Reset in the middle of a 20-step shift aborts it.
    launch(2'b00, 1'b0, 5'd20, 32'h0, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", {busy, done, carry_out, result}, 35'd0);
    reset = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    run("after_abort", 2'b00, 1'b0, 5'd20, 32'h0, 32'h0000_0001, 1'b0, 32'h0010_0000, 1'b0, 21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
